// File: rtl/vtg_pkg.sv
// ---------------------------------------------------------------------------
// vtg_pkg -- shared definitions for the video timing generator.
//
// Contents:
//   vtg_state_e : run-control FSM states (IDLE, RUN, DRAIN)
//   CNT_W       : width of the horizontal/vertical position counters
//   CNT_LIMIT   : largest H_TOTAL / V_TOTAL the counters can represent
//   vtg_stride(): byte distance between consecutive image rows
// ---------------------------------------------------------------------------
package vtg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vtg_state_e;

    localparam int CNT_W     = 12;
    localparam int CNT_LIMIT = 4096;

    // Row stride in bytes. With row_pad set, each row is padded to a 4-byte
    // boundary, as in an uncompressed BMP pixel array.
    function automatic int unsigned vtg_stride(input int unsigned h_active,
                                               input int unsigned bpp,
                                               input int unsigned row_pad);
        int unsigned raw;
        raw = h_active * bpp;
        if (row_pad != 0) begin
            return (raw + 32'd3) & ~32'd3;
        end
        return raw;
    endfunction

endpackage

// File: rtl/vtg_addr_gen.sv
// ---------------------------------------------------------------------------
// vtg_addr_gen -- converts active-relative pixel coordinates into the byte
// address of that pixel inside an image array (header + padded rows).
// One register stage; the output rests at HDR_OFFSET whenever active_i is 0.
//
// Ports:
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   x_i       : active-relative column (0 .. H_ACTIVE-1)
//   y_i       : active-relative line   (0 .. V_ACTIVE-1)
//   active_i  : coordinates are inside the active picture
//   index_o   : HDR_OFFSET + row*STRIDE + x*BPP, registered, 32-bit wrap
// ---------------------------------------------------------------------------
module vtg_addr_gen
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BPP        = 3,
    parameter int HDR_OFFSET = 54,
    parameter int ROW_PAD    = 1,
    parameter int BOTTOM_UP  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CNT_W-1:0]  x_i,
    input  logic [CNT_W-1:0]  y_i,
    input  logic              active_i,
    output logic [31:0]       index_o
);

    localparam int unsigned STRIDE = vtg_stride(H_ACTIVE, BPP, ROW_PAD);

    logic [31:0] row_w;
    logic [31:0] index_d;
    logic [31:0] index_q;

    always_comb begin
        // Bottom-up storage keeps the last displayed line first in memory.
        if (BOTTOM_UP != 0) begin
            row_w = 32'(V_ACTIVE - 1) - {{(32-CNT_W){1'b0}}, y_i};
        end else begin
            row_w = {{(32-CNT_W){1'b0}}, y_i};
        end

        index_d = 32'(HDR_OFFSET);
        if (active_i) begin
            index_d = 32'(HDR_OFFSET) + row_w * STRIDE
                    + {{(32-CNT_W){1'b0}}, x_i} * 32'(BPP);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            index_q <= 32'(HDR_OFFSET);
        end else begin
            index_q <= index_d;
        end
    end

    assign index_o = index_q;

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen -- raster timing generator with pixel byte addressing.
//
// Free-running h/v counters produce hsync/vsync, an active-pixel qualifier
// (href) and the byte address (index) of the current pixel in an image
// array. A run-control FSM starts frames on en and always finishes a frame
// once it has begun, even if en drops.
//
// Optional build macro: VTG_FRAME_CNT_EN -- when defined, frame_cnt counts
// completed frames (16-bit wrap); otherwise frame_cnt is constant 0.
//
// Ports:
//   clk         : clock
//   rst         : asynchronous active-high reset
//   en          : run request
//   hsync/vsync : sync outputs, asserted level HS_POL/VS_POL
//   href        : active-pixel qualifier
//   index       : byte address of the current pixel (HDR_OFFSET when href=0)
//   frame_start : one-cycle pulse at the first clock of a frame
//   frame_done  : one-cycle pulse at the last clock of a frame
//   frame_cnt   : completed-frame counter
//   dbg_state   : current FSM state, for observation only
//
// Stream contract: href/index form a valid-only stream with no back-pressure;
// index is meaningful exactly on cycles where href=1 and is consumed then.
//
// Latency: hsync/vsync/frame_start/frame_done lag the counters by one clock;
// href/index lag them by two (coordinate register + address register).
// ---------------------------------------------------------------------------
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   BPP        = 3,
    parameter int   HDR_OFFSET = 54,
    parameter int   ROW_PAD    = 1,
    parameter int   BOTTOM_UP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        href,
    output logic [31:0] index,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [1:0]  dbg_state
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);

    // Active window bounds in 13 bits so an end bound of 4096 is exact.
    localparam logic [CNT_W:0] H_ACT_BEG = (CNT_W+1)'(H_SYNC + H_BP);
    localparam logic [CNT_W:0] H_ACT_END = (CNT_W+1)'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W:0] V_ACT_BEG = (CNT_W+1)'(V_SYNC + V_BP);
    localparam logic [CNT_W:0] V_ACT_END = (CNT_W+1)'(V_SYNC + V_BP + V_ACTIVE);

    generate
        if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT || BPP < 1 || BPP > 4) begin : g_bad_cfg
            $fatal(1, "video_timing_gen: H_TOTAL/V_TOTAL must be <= 4096 and BPP in 1..4");
        end
    endgenerate

    vtg_state_e       state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    logic running;
    logic last_h;
    logic last_v;
    logic frame_last;
    logic in_active;

    assign running    = (state_q != IDLE);
    assign last_h     = (hcnt_q == H_MAX);
    assign last_v     = (vcnt_q == V_MAX);
    assign frame_last = last_h && last_v;
    assign in_active  = running
                     && ({1'b0, hcnt_q} >= H_ACT_BEG) && ({1'b0, hcnt_q} < H_ACT_END)
                     && ({1'b0, vcnt_q} >= V_ACT_BEG) && ({1'b0, vcnt_q} < V_ACT_END);

    // -----------------------------------------------------------------------
    // FSM + counters: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;

        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            // Re-request wins over stopping, so an en pulse landing on the
            // last clock of a frame continues straight into the next one.
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (frame_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (running) begin
            if (last_h) begin
                hcnt_d = '0;
                vcnt_d = last_v ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end else begin
            hcnt_d = '0;
            vcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output stage 1: syncs, frame pulses, active-relative coordinates
    // -----------------------------------------------------------------------
    logic             hsync_q, vsync_q;
    logic             frame_start_q, frame_done_q;
    logic             active_q, href_q;
    logic [CNT_W-1:0] x_q, y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            href_q        <= 1'b0;
        end else begin
            hsync_q       <= (running && hcnt_q < CNT_W'(H_SYNC)) ? HS_POL : ~HS_POL;
            vsync_q       <= (running && vcnt_q < CNT_W'(V_SYNC)) ? VS_POL : ~VS_POL;
            frame_start_q <= running && (hcnt_q == '0) && (vcnt_q == '0);
            frame_done_q  <= running && frame_last;
            active_q      <= in_active;
            x_q           <= hcnt_q - H_ACT_BEG[CNT_W-1:0];
            y_q           <= vcnt_q - V_ACT_BEG[CNT_W-1:0];
            // Stage 2: href waits for the address register to catch up.
            href_q        <= active_q;
        end
    end

    vtg_addr_gen #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .BPP        (BPP),
        .HDR_OFFSET (HDR_OFFSET),
        .ROW_PAD    (ROW_PAD),
        .BOTTOM_UP  (BOTTOM_UP)
    ) u_addr_gen (
        .clk_i    (clk),
        .rst_i    (rst),
        .x_i      (x_q),
        .y_i      (y_q),
        .active_i (active_q),
        .index_o  (index)
    );

`ifdef VTG_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Advances on the same edge that raises frame_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (running && frame_last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign href        = href_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen -- bench for video_timing_gen on a 7x6 raster
// (H 3/1/2/1, V 3/1/1/1, BPP 3, header 54, stride 12).
// Two instances share clock, reset and en: one top-down, one bottom-up.
// The reference model tracks only the linear position inside the frame
// (0..41, or -1 when stopped) and derives every output from it.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;
    import vtg_pkg::*;

    localparam int H_TOT  = 7;
    localparam int V_TOT  = 6;
    localparam int F_LEN  = H_TOT * V_TOT;
    localparam int HDR    = 54;
    localparam int STRIDE = 12;   // 3 px * 3 B = 9, padded to 12
    localparam int BPP_TB = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic        hs_td, vs_td, href_td, fs_td, fd_td;
    logic [31:0] idx_td;
    logic [15:0] cnt_td;
    logic [1:0]  st_td;
    logic        hs_bu, vs_bu, href_bu, fs_bu, fd_bu;
    logic [31:0] idx_bu;
    logic [15:0] cnt_bu;
    logic [1:0]  st_bu;

    video_timing_gen #(
        .H_ACTIVE(3), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .BPP(3), .HDR_OFFSET(54),
        .ROW_PAD(1), .BOTTOM_UP(0)
    ) u_dut_td (
        .clk(clk), .rst(rst), .en(en), .hsync(hs_td), .vsync(vs_td),
        .href(href_td), .index(idx_td), .frame_start(fs_td),
        .frame_done(fd_td), .frame_cnt(cnt_td), .dbg_state(st_td)
    );

    video_timing_gen #(
        .H_ACTIVE(3), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .BPP(3), .HDR_OFFSET(54),
        .ROW_PAD(1), .BOTTOM_UP(1)
    ) u_dut_bu (
        .clk(clk), .rst(rst), .en(en), .hsync(hs_bu), .vsync(vs_bu),
        .href(href_bu), .index(idx_bu), .frame_start(fs_bu),
        .frame_done(fd_bu), .frame_cnt(cnt_bu), .dbg_state(st_bu)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_pos  = -1;   // position this cycle
    int          m_pos1 = -1;   // one cycle ago
    int          m_pos2 = -1;   // two cycles ago
    logic        m_prev_en = 1'b0;
    logic [15:0] m_cnt = '0;

    // A frame ends the run only if en was low on its last two clocks.
    function automatic int next_pos(input int p, input logic e, input logic pe);
        if (p < 0) return e ? 0 : -1;
        if (p == F_LEN - 1) return (!e && !pe) ? -1 : 0;
        return p + 1;
    endfunction

    function automatic logic exp_hs(input int p);
        return (p >= 0 && (p % H_TOT) < 2) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_vs(input int p);
        return (p >= 0 && (p / H_TOT) < 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_act(input int p);
        int h, v;
        if (p < 0) return 1'b0;
        h = p % H_TOT;
        v = p / H_TOT;
        return (h >= 3 && h < 6 && v >= 2 && v < 5);
    endfunction

    function automatic logic [31:0] exp_idx(input int p, input int bu);
        int x, y, row;
        if (!exp_act(p)) return 32'(HDR);
        x   = (p % H_TOT) - 3;
        y   = (p / H_TOT) - 2;
        row = (bu != 0) ? (2 - y) : y;
        return 32'(HDR + row * STRIDE + x * BPP_TB);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos     <= -1;
            m_pos1    <= -1;
            m_pos2    <= -1;
            m_prev_en <= 1'b0;
            m_cnt     <= '0;
        end else begin
            m_pos2    <= m_pos1;
            m_pos1    <= m_pos;
            m_pos     <= next_pos(m_pos, en, m_prev_en);
            m_prev_en <= en;
            if (m_pos == F_LEN - 1) m_cnt <= m_cnt + 16'd1;
        end
    end

    logic [15:0] m_cnt_exp;
`ifdef VTG_FRAME_CNT_EN
    assign m_cnt_exp = m_cnt;
`else
    assign m_cnt_exp = 16'd0;
`endif

    // ---------------- compare + collectors ----------------
    int          cyc = 0;
    logic [31:0] got_td[$];
    logic [31:0] got_bu[$];
    int          fs_cyc_q[$];
    logic [31:0] cnt_seen_q[$];
    int          fd_n = 0;
    int          fd_cyc = 0;
    int          rise_n = 0;
    logic        href_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        check("hsync_td", {31'b0, hs_td}, {31'b0, exp_hs(m_pos1)});
        check("vsync_td", {31'b0, vs_td}, {31'b0, exp_vs(m_pos1)});
        check("fstart_td", {31'b0, fs_td}, {31'b0, m_pos1 == 0});
        check("fdone_td", {31'b0, fd_td}, {31'b0, m_pos1 == F_LEN - 1});
        check("href_td", {31'b0, href_td}, {31'b0, exp_act(m_pos2)});
        check("index_td", idx_td, exp_idx(m_pos2, 0));
        check("fcnt_td", {16'b0, cnt_td}, {16'b0, m_cnt_exp});
        check("idle_td", {31'b0, st_td == IDLE}, {31'b0, m_pos < 0});
        check("hsync_bu", {31'b0, hs_bu}, {31'b0, exp_hs(m_pos1)});
        check("vsync_bu", {31'b0, vs_bu}, {31'b0, exp_vs(m_pos1)});
        check("fstart_bu", {31'b0, fs_bu}, {31'b0, m_pos1 == 0});
        check("fdone_bu", {31'b0, fd_bu}, {31'b0, m_pos1 == F_LEN - 1});
        check("href_bu", {31'b0, href_bu}, {31'b0, exp_act(m_pos2)});
        check("index_bu", idx_bu, exp_idx(m_pos2, 1));
        check("fcnt_bu", {16'b0, cnt_bu}, {16'b0, m_cnt_exp});
        check("idle_bu", {31'b0, st_bu == IDLE}, {31'b0, m_pos < 0});

        if (href_td) got_td.push_back(idx_td);
        if (href_bu) got_bu.push_back(idx_bu);
        if (href_td && !href_prev) rise_n++;
        href_prev = href_td;
        if (fs_td) fs_cyc_q.push_back(cyc);
        if (fd_td) begin
            fd_n++;
            fd_cyc = cyc;
            cnt_seen_q.push_back({16'b0, cnt_td});
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && st_td != IDLE; i++) step();
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] exp_td_q[$];
    logic [31:0] exp_bu_q[$];
    int fd_base, got_base, fs_base;

    initial begin
        exp_td_q = '{32'd54, 32'd57, 32'd60, 32'd66, 32'd69, 32'd72, 32'd78, 32'd81, 32'd84};
        exp_bu_q = '{32'd78, 32'd81, 32'd84, 32'd66, 32'd69, 32'd72, 32'd54, 32'd57, 32'd60};

        // Reset, then stay idle with en=0.
        #1 rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        check("idle_after_reset", {31'b0, st_td == IDLE}, 32'd1);
        check("hsync_idle", {31'b0, hs_td}, 32'd1);
        check("fs_none_idle", 32'(fs_cyc_q.size()), 32'd0);

        // Three frames; en dips for 5 clocks in the middle of frame 2.
        en = 1'b1;
        for (int i = 0; i < 200 && fd_n < 3; i++) begin
            if (i == 60) en = 1'b0;
            if (i == 65) en = 1'b1;
            step();
        end
        check("three_frames_done", 32'(fd_n), 32'd3);
        check("frame_starts", 32'(fs_cyc_q.size()), 32'd3);
        if (fs_cyc_q.size() >= 3) begin
            check("fs_period_1", 32'(fs_cyc_q[1] - fs_cyc_q[0]), 32'd42);
            check("fs_period_2", 32'(fs_cyc_q[2] - fs_cyc_q[1]), 32'd42);
        end
        check("href_runs", 32'(rise_n), 32'd9);
        check("px_count_td", 32'(got_td.size()), 32'd27);
        check("px_count_bu", 32'(got_bu.size()), 32'd27);
        foreach (got_td[i]) check("px_td", got_td[i], exp_td_q[i % 9]);
        foreach (got_bu[i]) check("px_bu", got_bu[i], exp_bu_q[i % 9]);
        foreach (cnt_seen_q[i]) begin
`ifdef VTG_FRAME_CNT_EN
            check("fcnt_at_done", cnt_seen_q[i], 32'(i + 1));
`else
            check("fcnt_at_done", cnt_seen_q[i], 32'd0);
`endif
        end

        // Drop en mid-frame and hold it low: the frame completes, then idle.
        repeat (20) step();
        en = 1'b0;
        wait_idle(120);
        check("drained_to_idle", {31'b0, st_td == IDLE}, 32'd1);
        repeat (10) step();
        check("one_more_done", 32'(fd_n), 32'd4);
        check("px_after_drain", 32'(got_td.size()), 32'd36);
        check("hsync_inactive", {31'b0, hs_td}, 32'd1);
        check("vsync_inactive", {31'b0, vs_td}, 32'd1);

        // Reset in the middle of a line, then restart with en held high.
        en = 1'b1;
        repeat (31) step();
        rst = 1'b1;
        #1;
        check("rst_idle", {31'b0, st_td == IDLE}, 32'd1);
        check("rst_hsync", {31'b0, hs_td}, 32'd1);
        check("rst_vsync", {31'b0, vs_td}, 32'd1);
        check("rst_href", {31'b0, href_td}, 32'd0);
        check("rst_index", idx_td, 32'd54);
        check("rst_fs", {31'b0, fs_td}, 32'd0);
        check("rst_fd", {31'b0, fd_td}, 32'd0);
        check("rst_fcnt", {16'b0, cnt_td}, 32'd0);
        repeat (2) step();
        fd_base  = fd_n;
        got_base = got_td.size();
        fs_base  = fs_cyc_q.size();
        rst = 1'b0;
        for (int i = 0; i < 60 && fd_n == fd_base; i++) step();
        check("restart_done", 32'(fd_n - fd_base), 32'd1);
        check("restart_fs", 32'(fs_cyc_q.size() - fs_base), 32'd1);
        if (fs_cyc_q.size() > fs_base) check("restart_len", 32'(fd_cyc - fs_cyc_q[$]), 32'd41);
        check("restart_px", 32'(got_td.size() - got_base), 32'd9);
        for (int i = got_base; i < got_td.size(); i++) check("restart_px_td", got_td[i], exp_td_q[(i - got_base) % 9]);
`ifdef VTG_FRAME_CNT_EN
        check("restart_fcnt", cnt_seen_q[$], 32'd1);
`else
        check("restart_fcnt", cnt_seen_q[$], 32'd0);
`endif

        en = 1'b0;
        wait_idle(100);
        check("final_idle", {31'b0, st_td == IDLE}, 32'd1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porches and sync width in clocks.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical lines.
REQ-004 SHALL have parameters HS_POL/VS_POL, default 0/0, asserted level of hsync/vsync.
REQ-005 SHALL have parameter BPP, default 3, bytes per pixel, legal range 1..4.
REQ-006 SHALL have parameter HDR_OFFSET, default 54, byte offset of pixel 0 in the image array.
REQ-007 SHALL have parameter ROW_PAD, default 1; when 1, row stride rounds up to a multiple of 4 bytes.
REQ-008 SHALL have parameter BOTTOM_UP, default 1; when 1, row y maps to storage row V_ACTIVE-1-y.
REQ-009 Ports: clk in 1, sole clock; rst in 1, asynchronous, active-high reset.
REQ-010 Ports: en in 1, run request; hsync out 1; vsync out 1; href out 1, active-pixel qualifier.
REQ-011 Ports: index out 32, byte address of current pixel; frame_start out 1; frame_done out 1; frame_cnt out 16.

Function
REQ-012 SHALL use FSM states IDLE, RUN, DRAIN; H_TOTAL = sum of H params; V_TOTAL = sum of V params.
REQ-013 IDLE: hcnt=vcnt=0 held; en=1 -> RUN on the next edge, counting starts from hcnt=0, vcnt=0.
REQ-014 RUN: hcnt wraps H_TOTAL-1 -> 0; vcnt increments at hcnt wrap and wraps V_TOTAL-1 -> 0; en=0 -> DRAIN.
REQ-015 DRAIN: counting continues; en=1 -> RUN with no counter disturbance; at hcnt=H_TOTAL-1 & vcnt=V_TOTAL-1 -> IDLE.
REQ-016 hsync SHALL be HS_POL when hcnt<H_SYNC, else ~HS_POL; vsync same with vcnt<V_SYNC; both registered one cycle after the counters; inactive level in IDLE.
REQ-017 Active region: V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACTIVE and H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE.
REQ-018 href SHALL assert exactly two cycles after the counters enter the active region and stay high for H_ACTIVE cycles per line.
REQ-019 index SHALL be cycle-aligned with href: HDR_OFFSET + row*STRIDE + x*BPP, 32-bit unsigned arithmetic, with x,y as active-relative coordinates.
REQ-020 STRIDE = H_ACTIVE*BPP, rounded up to a multiple of 4 when ROW_PAD=1; row = BOTTOM_UP ? V_ACTIVE-1-y : y.
REQ-021 While href=0, index SHALL equal HDR_OFFSET.
REQ-022 frame_start SHALL pulse one cycle, registered, when hcnt=0 & vcnt=0 in RUN or DRAIN.
REQ-023 frame_done SHALL pulse one cycle, registered, at the last clock of each frame (both counters at their maximum).
REQ-024 frame_cnt SHALL increment, wrapping at 16 bits, on each frame_done.
REQ-025 en toggling mid-frame SHALL never truncate a frame; a frame started is always completed.

Reset
REQ-026 rst=1 SHALL force FSM=IDLE, hcnt=vcnt=0, hsync=~HS_POL, vsync=~VS_POL, href=0, index=HDR_OFFSET, frame_start=frame_done=0, frame_cnt=0, including mid-frame.
REQ-027 After rst is released, the first frame SHALL begin only after en=1 is sampled.

Configuration
REQ-028 Macro VTG_FRAME_CNT_EN: when defined, frame_cnt counts per REQ-024; when undefined, frame_cnt is tied to 0 and its counter logic is omitted; all other behaviour is identical.

Structure
REQ-029 Package vtg_pkg SHALL hold the FSM state enum and a constant function computing STRIDE from H_ACTIVE, BPP and ROW_PAD.
REQ-030 Address arithmetic SHALL live in sub-module vtg_addr_gen (x, y, active in; index out; one register stage).
REQ-031 Counters SHALL be 12 bits wide; elaboration SHALL fail if H_TOTAL or V_TOTAL exceeds 4096, or if BPP is outside 1..4.

Verification (H_ACTIVE=3, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, BPP=3, HDR_OFFSET=54, ROW_PAD=1 -> STRIDE=12)
REQ-032 BOTTOM_UP=0, en=1: line 0 href run gives index 54, 57, 60; line 1 gives 66, 69, 72; 3 href pulses per frame.
REQ-033 BOTTOM_UP=1: the first href run gives index 78, 81, 84, and the last run gives 54, 57, 60.
REQ-034 Drop en mid-frame, then hold en=0: the frame completes, frame_done pulses once, the FSM returns to IDLE, and hsync/vsync go inactive.
REQ-035 Drop en and reassert it within the same frame: there is no gap, frame_start recurs every 42 cycles (7x6), and frame_cnt counts 1, 2, 3.
REQ-036 Assert rst mid-line: all outputs reach REQ-026 values immediately; with en=1 after release, a full frame restarts from hcnt=0.
REQ-037 Build without VTG_FRAME_CNT_EN: frame_cnt stays 0 over 3 frames, and all other outputs match REQ-032.
